// File: rtl/result_serializer_if.sv
// Handshake bundle for result_serializer: wide dequeue side from the output FIFO
// and the 32-bit beat stream towards the host/DMA.
interface result_serializer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 255
);
  logic [NUM_WORDS*WORD_WIDTH-1:0] data_in;
  logic                            valid_in;
  logic                            ready_out;
  logic [WORD_WIDTH-1:0]           data_out;
  logic                            valid_out;
  logic                            ready_in;
  logic                            last_out;
  logic                            busy;

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last_out, busy
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last_out, busy
  );
endinterface

// File: rtl/result_serializer.sv
// Captures one NUM_WORDS x WORD_WIDTH result vector and streams it out one word per beat.
// Optional frame counter output enabled by defining RESULT_SER_FRAME_CNT_EN.
module result_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  result_serializer_if.slave   io
`ifdef RESULT_SER_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_WORDS*WORD_WIDTH-1:0] buf_q, buf_d;

  logic fire;
  logic last_beat;
  logic take;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers; combinational blocks use blocking ones.
  // NOTE: the shadow register is a plain flop bank, so it is cleared on reset
  // to keep data_out free of X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    io.valid_out  = 1'b0;
    io.busy       = 1'b0;
    io.last_out   = 1'b0;
    io.data_out   = '0;

    last_beat = (idx_q == LAST_IDX);
    fire      = (state_q == SEND) && io.ready_in;

    if (state_q == SEND) begin
      io.valid_out = 1'b1;
      io.busy      = 1'b1;
      io.last_out  = last_beat;
      io.data_out  = buf_q[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH];
    end

    // A new vector is only dequeued when idle or as the final beat leaves.
    io.ready_out = !rst && ((state_q == IDLE) || (fire && last_beat));
    take         = io.valid_in && io.ready_out;

    if (take) begin
      buf_d   = io.data_in;
      idx_d   = '0;
      state_d = SEND;
    end else if (fire) begin
      if (last_beat) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

`ifdef RESULT_SER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fire && last_beat) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: 4-word and default-size instances,
// plus a 1-word instance exercising the frame counter when it is enabled.
module tb_result_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  result_serializer_if #(.WORD_WIDTH(32), .NUM_WORDS(4))   if4 ();
  result_serializer_if #(.WORD_WIDTH(32), .NUM_WORDS(255)) if255 ();
  result_serializer_if #(.WORD_WIDTH(32), .NUM_WORDS(1))   if1 ();

`ifdef RESULT_SER_FRAME_CNT_EN
  logic [15:0] fc4, fc255, fc1;
`endif

  result_serializer #(.WORD_WIDTH(32), .NUM_WORDS(4)) u4 (
    .clk(clk), .rst(rst), .io(if4)
`ifdef RESULT_SER_FRAME_CNT_EN
    , .frame_cnt(fc4)
`endif
  );

  result_serializer #(.WORD_WIDTH(32), .NUM_WORDS(255)) u255 (
    .clk(clk), .rst(rst), .io(if255)
`ifdef RESULT_SER_FRAME_CNT_EN
    , .frame_cnt(fc255)
`endif
  );

  result_serializer #(.WORD_WIDTH(32), .NUM_WORDS(1)) u1 (
    .clk(clk), .rst(rst), .io(if1)
`ifdef RESULT_SER_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic l, input logic r);
    check({tag, ".valid"}, 32'(if4.valid_out), 32'd1);
    check({tag, ".data"},  if4.data_out, d);
    check({tag, ".last"},  32'(if4.last_out), 32'(l));
    check({tag, ".rdy"},   32'(if4.ready_out), 32'(r));
  endtask

  task automatic expect_idle4(input string tag);
    check({tag, ".valid"}, 32'(if4.valid_out), 32'd0);
    check({tag, ".busy"},  32'(if4.busy), 32'd0);
  endtask

  // Hard stop so the bench can never hang.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  localparam logic [127:0] V1 = {32'hD, 32'hC, 32'hB, 32'hA};
  localparam logic [127:0] V2 = {32'h14, 32'h13, 32'h12, 32'h11};

  initial begin
    int cnt;
    int fired;

    if4.data_in = '0;   if4.valid_in = 1'b0;   if4.ready_in = 1'b1;
    if255.data_in = '0; if255.valid_in = 1'b0; if255.ready_in = 1'b1;
    if1.data_in = '0;   if1.valid_in = 1'b0;   if1.ready_in = 1'b1;

    // Reset state, with valid_in high to show ready_out is held low in reset.
    repeat (2) @(negedge clk);
    if4.valid_in = 1'b1; if4.data_in = V1;
    #1;
    check("rst.valid", 32'(if4.valid_out), 32'd0);
    check("rst.last",  32'(if4.last_out), 32'd0);
    check("rst.busy",  32'(if4.busy), 32'd0);
    check("rst.data",  if4.data_out, 32'd0);
    check("rst.rdy",   32'(if4.ready_out), 32'd0);
    check("rst.data255", if255.data_out, 32'd0);

    // Single vector, no backpressure.
    @(negedge clk);
    rst = 1'b0;
    #1 check("t1.take_rdy", 32'(if4.ready_out), 32'd1);
    @(negedge clk); if4.valid_in = 1'b0; #1 expect_beat("t1.A", 32'hA, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t1.B", 32'hB, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t1.C", 32'hC, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t1.D", 32'hD, 1'b1, 1'b1);
    @(negedge clk); #1 expect_idle4("t1.end");

    // Two queued vectors stream with no bubble.
    if4.valid_in = 1'b1; if4.data_in = V1;
    @(negedge clk); if4.data_in = V2; #1 expect_beat("t2.A", 32'hA, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t2.B", 32'hB, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t2.C", 32'hC, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t2.D", 32'hD, 1'b1, 1'b1);
    @(negedge clk); #1 expect_beat("t2.E", 32'h11, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t2.F", 32'h12, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t2.G", 32'h13, 1'b0, 1'b0);
    @(negedge clk); if4.valid_in = 1'b0; #1 expect_beat("t2.H", 32'h14, 1'b1, 1'b1);
    @(negedge clk); #1 expect_idle4("t2.end");

    // Backpressure on beat B; a pending upstream vector must not be dequeued.
    if4.valid_in = 1'b1; if4.data_in = V1;
    @(negedge clk); if4.valid_in = 1'b0; #1 expect_beat("t3.A", 32'hA, 1'b0, 1'b0);
    @(negedge clk); if4.ready_in = 1'b0; if4.valid_in = 1'b1; if4.data_in = V2;
    #1 expect_beat("t3.stall0", 32'hB, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t3.stall1", 32'hB, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t3.stall2", 32'hB, 1'b0, 1'b0);
    @(negedge clk); if4.ready_in = 1'b1; if4.valid_in = 1'b0;
    #1 expect_beat("t3.B", 32'hB, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t3.C", 32'hC, 1'b0, 1'b0);
    @(negedge clk); #1 expect_beat("t3.D", 32'hD, 1'b1, 1'b1);
    @(negedge clk); #1 expect_idle4("t3.end");

    // Asynchronous reset in the middle of a frame.
    if4.valid_in = 1'b1; if4.data_in = V1;
    @(negedge clk); if4.valid_in = 1'b0;
    @(negedge clk); #1 expect_beat("t4.B", 32'hB, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t4.valid", 32'(if4.valid_out), 32'd0);
    check("t4.last",  32'(if4.last_out), 32'd0);
    check("t4.busy",  32'(if4.busy), 32'd0);
    check("t4.rdy",   32'(if4.ready_out), 32'd0);
    check("t4.data",  if4.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0; if4.valid_in = 1'b1; if4.data_in = V2;
    #1 check("t4.take_rdy", 32'(if4.ready_out), 32'd1);
    @(negedge clk); if4.valid_in = 1'b0; #1 expect_beat("t4.word0", 32'h11, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1 expect_idle4("t4.end");

    // Default geometry with random downstream stalls.
    for (int k = 0; k < 255; k++) if255.data_in[k*32 +: 32] = 32'h100 + 32'(k);
    if255.valid_in = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 3000 && cnt < 255; cyc++) begin
      @(negedge clk);
      if255.valid_in = 1'b0;
      if255.ready_in = 1'($urandom_range(0, 1));
      #1;
      if (if255.valid_out && if255.ready_in) begin
        check("t5.data", if255.data_out, 32'h100 + 32'(cnt));
        check("t5.last", 32'(if255.last_out), 32'(cnt == 254));
        cnt++;
      end
    end
    check("t5.count", 32'(cnt), 32'd255);
    @(negedge clk);
    #1 check("t5.idle", 32'(if255.valid_out), 32'd0);
    if255.ready_in = 1'b1;

`ifdef RESULT_SER_FRAME_CNT_EN
    // One-word frames: every beat is last; counter wraps after 65536 frames.
    check("t6.cnt0", 32'(fc1), 32'd0);
    if1.data_in = 32'h55; if1.valid_in = 1'b1; if1.ready_in = 1'b1;
    fired = 0;
    for (int cyc = 0; cyc < 70000 && fired < 65537; cyc++) begin
      @(negedge clk);
      #1;
      if (if1.valid_out && if1.ready_in) begin
        fired++;
        if (fired == 65537) if1.valid_in = 1'b0;
      end
    end
    check("t6.fired", 32'(fired), 32'd65537);
    @(negedge clk);
    #1;
    check("t6.wrap", 32'(fc1), 32'd1);
    check("t6.idle", 32'(if1.valid_out), 32'd0);

    // Counter holds while the single beat is stalled; ready_out tracks ready_in.
    if1.valid_in = 1'b1; if1.ready_in = 1'b0;
    @(negedge clk); if1.valid_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t6.stall_cnt",  32'(fc1), 32'd1);
      check("t6.stall_last", 32'(if1.last_out), 32'd1);
      check("t6.stall_rdy",  32'(if1.ready_out), 32'd0);
      @(negedge clk);
    end
    if1.ready_in = 1'b1;
    #1 check("t6.rdy_follow", 32'(if1.ready_out), 32'd1);
    @(negedge clk);
    #1 check("t6.cnt2", 32'(fc1), 32'd2);
`else
    fired = 0;
    check("t6.u1_idle", 32'(if1.valid_out), 32'(fired));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Drains the wide detection-result words from the core's output FIFO and streams them out as one 32-bit word per beat.
- Each word is NUM_WORDS x WORD_WIDTH bits; the default is 255 x 32.
- The upstream side is a valid/ready dequeue handshake with the output FIFO. The downstream side is a valid/ready stream to the host/DMA.
- Holds one captured vector at a time. Back-to-back vectors stream with no bubble between frames.

Parameters:
- WORD_WIDTH, 32, width of one output beat.
- NUM_WORDS, 255, beats per input vector.
- IDX_W, $clog2(NUM_WORDS), beat index width (derived; do not override).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- data_in  input  NUM_WORDS*WORD_WIDTH  wide result vector; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- valid_in  input  1  data_in is valid (upstream FIFO not empty).
- ready_out  output  1  dequeue strobe to the upstream FIFO; a transfer occurs when valid_in && ready_out.
- data_out  output  WORD_WIDTH  current beat.
- valid_out  output  1  data_out is valid.
- ready_in  input  1  downstream accepts the beat; a beat fires when valid_out && ready_in.
- last_out  output  1  high with the final beat (index NUM_WORDS-1) of a vector.
- busy  output  1  high whenever state is SEND.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE, idx=0, shadow register cleared to 0.
  - Outputs: valid_out=0, last_out=0, busy=0, data_out=0, ready_out=0 while Rst is high.
- Internal state: shadow register `buf` (NUM_WORDS*WORD_WIDTH bits), index `idx`, state in {IDLE, SEND}.
- ready_out is combinational, high only when Rst=0 and either:
  - state==IDLE, or
  - state==SEND with the final beat firing (idx==NUM_WORDS-1 && ready_in).
- take = valid_in && ready_out. On take, buf<=data_in, idx<=0, state<=SEND.
- IDLE: valid_out=0. On take, go to SEND. First beat is valid the cycle after take (latency 1).
- SEND:
  - valid_out=1.
  - data_out=buf word[idx], driven as a combinational mux from registered buf/idx.
  - last_out=(idx==NUM_WORDS-1).
- SEND, beat fires with idx<NUM_WORDS-1: idx<=idx+1.
- SEND, beat fires with idx==NUM_WORDS-1:
  - If take in the same cycle: reload buf, idx<=0, stay in SEND (zero-bubble).
  - Otherwise: state<=IDLE, idx<=0.
- Stall: while valid_out && !ready_in, data_out, last_out and idx hold stable. No new dequeue occurs mid-frame.
- valid_in falling while in SEND has no effect; the captured vector is fully sent.
- NUM_WORDS=1: every beat is last. ready_out follows ready_in while in SEND.
- Reset asserted mid-frame: the remainder of the frame is discarded. The vector already dequeued is lost; this is intentional, and the host re-runs the frame.
- Outputs never go X after reset. idx never exceeds NUM_WORDS-1.

Optional Feature:
- Macro: RESULT_SER_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt [15:0]. Reset value is 0.
  - Increments by 1 on every fired last beat, and wraps 16'hFFFF -> 16'h0000.
  - Unaffected by stalls.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- NUM_WORDS=4, vector {32'hD,32'hC,32'hB,32'hA}, valid_in=1 for one take, ready_in=1:
  - ready_out pulses once.
  - Beats A,B,C,D appear on cycles take+1..take+4, with last_out only on D.
  - Then valid_out=0 and busy=0.
- NUM_WORDS=4, two vectors queued (valid_in held high), ready_in=1:
  - 8 consecutive valid beats with no gap.
  - ready_out high exactly on the cycles where D and the second frame's last word fire.
- Backpressure, NUM_WORDS=4: ready_in low for 3 cycles while beat B is presented:
  - data_out stays 32'hB and valid_out stays 1 throughout.
  - No ready_out pulse; frame completes after ready_in returns.
- Reset mid-frame: assert Rst asynchronously (between clock edges) after beat B:
  - valid_out, last_out, busy and ready_out drop immediately; data_out=0.
  - After release with valid_in=1, the next take starts at word 0.
- Default params (255x32), word k = k+32'h100, ready_in randomly toggled:
  - Beats 0x100..0x1FE arrive in order; last_out only on 0x1FE; count = 255.
- With RESULT_SER_FRAME_CNT_EN, NUM_WORDS=1:
  - Send 65537 frames; frame_cnt ends at 1 (wrap verified).
  - frame_cnt does not change during stalls.
